// File: rtl/mod_counter.sv
// Up/down modulo counter with clamp-on-load, optional saturation at the bounds,
// a one-cycle wrap pulse and a sticky overflow flag.
module mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX      = (2 ** WIDTH) - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             at_top, at_bot, bound;

    assign at_top = (out_q == MAX_V);
    assign at_bot = (out_q == '0);
    // A bound event is exactly the terminal-count condition; clr/load only mask its effect.
    assign bound  = en & ((dir & at_top) | (~dir & at_bot));

    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        if (clr) begin
            out_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            out_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            if (bound) begin
                wrap_d = 1'b1;
                ovf_d  = 1'b1;
                if (!SATURATE) begin
                    out_d = dir ? '0 : MAX_V;
                end
            end else begin
                out_d = dir ? (out_q + ONE_V) : (out_q - ONE_V);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;
    assign tc   = bound;

endmodule
